// File: rtl/mem_bridge_pkg.sv
// Shared definitions for mem_bridge: region map, region/state encodings and
// the ack timeout limit used when MEM_TIMEOUT_EN is defined.
package mem_bridge_pkg;

    localparam logic [26:0] SDRAM_BASE = 27'h0000000;
    localparam logic [26:0] SDRAM_LIMIT = 27'h07FFFFF;
    localparam logic [26:0] ROM_BASE = 27'h0800000;
    localparam logic [26:0] ROM_LIMIT = 27'h08001FF;
    localparam logic [26:0] VRAM_BASE = 27'h0C00000;
    localparam logic [26:0] VRAM_LIMIT = 27'h0C03FFF;
    localparam logic [26:0] IO_BASE = 27'h0C04000;
    localparam logic [26:0] IO_LIMIT = 27'h0C040FF;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

    typedef enum logic [2:0] {
        REGION_SDRAM,
        REGION_ROM,
        REGION_VRAM,
        REGION_IO,
        REGION_UNMAPPED
    } region_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    function automatic logic in_range(input logic [26:0] addr,
                                      input logic [26:0] lo,
                                      input logic [26:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/mem_addr_decoder.sv
// Combinational decode of a 27-bit CPU word address into its target region.
module mem_addr_decoder
    import mem_bridge_pkg::*;
(
    input  logic [26:0] address,
    output region_e     region
);

    // First matching window wins; anything outside all windows is unmapped
    always_comb begin
        region = REGION_UNMAPPED;
        if (in_range(address, SDRAM_BASE, SDRAM_LIMIT)) begin
            region = REGION_SDRAM;
        end else if (in_range(address, ROM_BASE, ROM_LIMIT)) begin
            region = REGION_ROM;
        end else if (in_range(address, VRAM_BASE, VRAM_LIMIT)) begin
            region = REGION_VRAM;
        end else if (in_range(address, IO_BASE, IO_LIMIT)) begin
            region = REGION_IO;
        end else begin
            region = REGION_UNMAPPED;
        end
    end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: single-request CPU bridge to SDRAM, ROM, VRAM and IO targets.
// Define MEM_TIMEOUT_EN to add the SDRAM/IO ack timeout and the bus_error pulse.
module mem_bridge
    import mem_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [26:0] address,
    input  logic [31:0] data,
    input  logic        we,
    input  logic        start,
    output logic [31:0] q,
    output logic        busy,
    output logic [22:0] sd_addr,
    output logic [31:0] sd_d,
    output logic        sd_we,
    output logic        sd_req,
    input  logic [31:0] sd_q,
    input  logic        sd_ack,
    output logic [8:0]  rom_addr,
    input  logic [31:0] rom_q,
    output logic [13:0] vram_addr,
    output logic [31:0] vram_d,
    output logic        vram_we,
    input  logic [31:0] vram_q,
    output logic [7:0]  io_addr,
    output logic [31:0] io_d,
    output logic        io_we,
    output logic        io_req,
    input  logic [31:0] io_q,
    input  logic        io_ack
`ifdef MEM_TIMEOUT_EN
    ,
    output logic        bus_error
`endif
);

    region_e     region_s;
    region_e     region_r;
    state_e      state_r;
    logic        we_r;
    logic        target_ack_s;
    logic [31:0] target_q_s;
`ifdef MEM_TIMEOUT_EN
    logic [7:0]  wait_cnt_r;
`endif

    mem_addr_decoder u_decoder (
        .address (address),
        .region  (region_s)
    );

    // Handshake of the slow target selected by the current access only
    always_comb begin
        target_ack_s = 1'b0;
        target_q_s = 32'h0000_0000;
        case (region_r)
            REGION_SDRAM: begin
                target_ack_s = sd_ack;
                target_q_s = sd_q;
            end
            REGION_IO: begin
                target_ack_s = io_ack;
                target_q_s = io_q;
            end
            default: begin
                target_ack_s = 1'b0;
                target_q_s = 32'h0000_0000;
            end
        endcase
    end

    // Access sequencer; target outputs are loaded on accept so they are valid during ISSUE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            region_r <= REGION_UNMAPPED;
            we_r <= 1'b0;
            q <= 32'h0000_0000;
            busy <= 1'b0;
            sd_addr <= 23'h0;
            sd_d <= 32'h0000_0000;
            sd_we <= 1'b0;
            sd_req <= 1'b0;
            rom_addr <= 9'h0;
            vram_addr <= 14'h0;
            vram_d <= 32'h0000_0000;
            vram_we <= 1'b0;
            io_addr <= 8'h0;
            io_d <= 32'h0000_0000;
            io_we <= 1'b0;
            io_req <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_r <= 8'd0;
            bus_error <= 1'b0;
`endif
        end else begin
            vram_we <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            bus_error <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (start) begin
                        region_r <= region_s;
                        we_r <= we;
                        busy <= 1'b1;
                        state_r <= ISSUE;
                        case (region_s)
                            REGION_SDRAM: begin
                                sd_addr <= address[22:0];
                                sd_d <= data;
                                sd_we <= we;
                                sd_req <= 1'b1;
                            end
                            REGION_ROM: rom_addr <= address[8:0];
                            REGION_VRAM: begin
                                vram_addr <= address[13:0];
                                vram_d <= data;
                                vram_we <= we;
                            end
                            REGION_IO: begin
                                io_addr <= address[7:0];
                                io_d <= data;
                                io_we <= we;
                                io_req <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ISSUE: begin
`ifdef MEM_TIMEOUT_EN
                    wait_cnt_r <= 8'd0;
`endif
                    if (region_r == REGION_UNMAPPED) begin
                        if (!we_r) begin
                            q <= 32'h0000_0000;
                        end
                        state_r <= DONE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    case (region_r)
                        REGION_ROM: begin
                            if (!we_r) begin
                                q <= rom_q;
                            end
                            state_r <= DONE;
                        end
                        REGION_VRAM: begin
                            if (!we_r) begin
                                q <= vram_q;
                            end
                            state_r <= DONE;
                        end
                        REGION_SDRAM, REGION_IO: begin
                            if (target_ack_s) begin
                                if (!we_r) begin
                                    q <= target_q_s;
                                end
                                sd_req <= 1'b0;
                                sd_we <= 1'b0;
                                io_req <= 1'b0;
                                io_we <= 1'b0;
                                state_r <= DONE;
                            end
`ifdef MEM_TIMEOUT_EN
                            // Timeout fires on the 255th WAIT cycle without an ack
                            else if (wait_cnt_r == (TIMEOUT_LIMIT - 8'd1)) begin
                                if (!we_r) begin
                                    q <= 32'h0000_0000;
                                end
                                sd_req <= 1'b0;
                                sd_we <= 1'b0;
                                io_req <= 1'b0;
                                io_we <= 1'b0;
                                bus_error <= 1'b1;
                                state_r <= DONE;
                            end else begin
                                wait_cnt_r <= wait_cnt_r + 8'd1;
                            end
`endif
                        end
                        default: state_r <= DONE;
                    endcase
                end
                DONE: begin
                    busy <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: target device models plus a flat-memory
// reference of what each CPU access should return and how long it should take.
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [26:0] address = 27'h0;
    logic [31:0] data = 32'h0;
    logic        we = 1'b0;
    logic        start = 1'b0;
    logic [31:0] q;
    logic        busy;
    logic [22:0] sd_addr;
    logic [31:0] sd_d;
    logic        sd_we;
    logic        sd_req;
    logic [31:0] sd_q;
    logic        sd_ack;
    logic [8:0]  rom_addr;
    logic [31:0] rom_q;
    logic [13:0] vram_addr;
    logic [31:0] vram_d;
    logic        vram_we;
    logic [31:0] vram_q;
    logic [7:0]  io_addr;
    logic [31:0] io_d;
    logic        io_we;
    logic        io_req;
    logic [31:0] io_q;
    logic        io_ack;
`ifdef MEM_TIMEOUT_EN
    logic        bus_error;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rom_img   [0:511];
    logic [31:0] sdram_mem [0:1023];
    logic [31:0] vram_mem  [0:16383];
    logic [31:0] io_mem    [0:255];
    bit   [31:0] ref_mem   [int];
    logic [31:0] exp_q = 32'h0;

    int   sd_delay = 1;
    int   io_delay = 1;
    int   sd_cnt = 0;
    int   io_cnt = 0;
    logic sd_ack_r = 1'b0;
    logic io_ack_r = 1'b0;
    logic sd_ack_x = 1'b0;
    logic io_ack_x = 1'b0;
    bit   poke_start = 1'b0;

    mem_bridge dut (
        .clk(clk), .reset(reset), .address(address), .data(data), .we(we),
        .start(start), .q(q), .busy(busy),
        .sd_addr(sd_addr), .sd_d(sd_d), .sd_we(sd_we), .sd_req(sd_req),
        .sd_q(sd_q), .sd_ack(sd_ack),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .vram_addr(vram_addr), .vram_d(vram_d), .vram_we(vram_we), .vram_q(vram_q),
        .io_addr(io_addr), .io_d(io_d), .io_we(io_we), .io_req(io_req),
        .io_q(io_q), .io_ack(io_ack)
`ifdef MEM_TIMEOUT_EN
        , .bus_error(bus_error)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous ROM and VRAM devices
    always @(posedge clk) begin
        rom_q <= rom_img[rom_addr];
        if (vram_we) vram_mem[vram_addr] <= vram_d;
        vram_q <= vram_mem[vram_addr];
    end

    // SDRAM/IO devices: ack in the delay-th cycle after req rises (delay 0 = never)
    assign sd_ack = sd_ack_r | sd_ack_x;
    assign io_ack = io_ack_r | io_ack_x;
    assign sd_q = sdram_mem[sd_addr[9:0]];
    assign io_q = io_mem[io_addr];

    always @(posedge clk) begin
        if (!sd_req) begin
            sd_cnt <= 0;
            sd_ack_r <= 1'b0;
        end else begin
            sd_cnt <= sd_cnt + 1;
            sd_ack_r <= (sd_cnt + 1 == sd_delay);
            if (sd_ack && sd_we) sdram_mem[sd_addr[9:0]] <= sd_d;
        end
        if (!io_req) begin
            io_cnt <= 0;
            io_ack_r <= 1'b0;
        end else begin
            io_cnt <= io_cnt + 1;
            io_ack_r <= (io_cnt + 1 == io_delay);
            if (io_ack && io_we) io_mem[io_addr] <= io_d;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0 SDRAM, 1 ROM, 2 VRAM, 3 IO, 4 unmapped
    function automatic int region_of(input logic [26:0] a);
        if (a <= 27'h07FFFFF) return 0;
        if (a >= 27'h0800000 && a <= 27'h08001FF) return 1;
        if (a >= 27'h0C00000 && a <= 27'h0C03FFF) return 2;
        if (a >= 27'h0C04000 && a <= 27'h0C040FF) return 3;
        return 4;
    endfunction

    // One CPU access starting in the current (idle) cycle; returns in the cycle busy is low again
    task automatic do_access(input string tag, input logic [26:0] a, input logic [31:0] d,
                             input logic w, input int delay);
        int rg, exp_busy, n_busy, n_sdreq, n_ioreq, n_vwe, n_berr;
        bit tmo, stable;
        logic first_busy;
        rg = region_of(a);
        tmo = (rg == 0 || rg == 3) && (delay == 0);
        case (rg)
            0, 3:    exp_busy = tmo ? 257 : delay + 2;
            1, 2:    exp_busy = 3;
            default: exp_busy = 2;
        endcase
        if (w) begin
            if (!tmo && (rg == 0 || rg == 2 || rg == 3)) ref_mem[int'(a)] = d;
        end else begin
            if (tmo || rg == 4) exp_q = 32'h0;
            else if (rg == 1) exp_q = rom_img[a - 27'h0800000];
            else exp_q = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
        end
        sd_delay = delay;
        io_delay = delay;
        address = a; data = d; we = w; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        first_busy = busy;
        n_busy = 0; n_sdreq = 0; n_ioreq = 0; n_vwe = 0; n_berr = 0; stable = 1'b1;
        while (busy && n_busy < 400) begin
            n_busy++;
            if (sd_req) begin
                n_sdreq++;
                if (sd_addr !== a[22:0] || sd_we !== w || (w && sd_d !== d)) stable = 1'b0;
            end
            if (io_req) begin
                n_ioreq++;
                if (io_addr !== a[7:0] || io_we !== w || (w && io_d !== d)) stable = 1'b0;
            end
            if (vram_we) n_vwe++;
`ifdef MEM_TIMEOUT_EN
            if (bus_error) n_berr++;
`endif
            if (poke_start && n_busy == 2) begin
                start = 1'b1;
                address = 27'h0C04100;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, "_busy_rise"}, first_busy, 1);
        check({tag, "_busy_cycles"}, n_busy, exp_busy);
        check({tag, "_q"}, q, exp_q);
        if (rg == 0) begin
            check({tag, "_sd_req_cycles"}, n_sdreq, tmo ? 256 : delay + 1);
            check({tag, "_sd_stable"}, stable, 1);
        end else if (rg == 3) begin
            check({tag, "_io_req_cycles"}, n_ioreq, tmo ? 256 : delay + 1);
            check({tag, "_io_stable"}, stable, 1);
        end else if (rg == 2) begin
            check({tag, "_vram_we_cycles"}, n_vwe, w ? 1 : 0);
        end else begin
            check({tag, "_no_target"}, n_sdreq + n_ioreq + n_vwe, 0);
        end
`ifdef MEM_TIMEOUT_EN
        check({tag, "_bus_error"}, n_berr, tmo ? 1 : 0);
`endif
    endtask

    logic [26:0] bnd_addrs [0:8];

    initial begin
        logic [31:0] vd;
        logic [26:0] ra;
        int rsel;
        for (int i = 0; i < 512; i++) rom_img[i] = $urandom;
        rom_img[5] = 32'hDEADBEEF;
        for (int i = 0; i < 1024; i++) sdram_mem[i] = 32'h0;
        for (int i = 0; i < 16384; i++) vram_mem[i] = 32'h0;
        for (int i = 0; i < 256; i++) io_mem[i] = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_q", q, 0);
        check("rst_reqs", {sd_req, io_req, sd_we, io_we, vram_we}, 0);
        check("rst_addrs", {sd_addr, rom_addr}, 0);
        check("rst_addrs2", {vram_addr, io_addr}, 0);
        check("rst_data", sd_d | vram_d | io_d, 0);
`ifdef MEM_TIMEOUT_EN
        check("rst_bus_error", bus_error, 0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;

        do_access("rom_rd", 27'h0800005, 32'h0, 1'b0, 1);
        check("rom_rd_const", q, 32'hDEADBEEF);
        poke_start = 1'b1;
        do_access("sd_wr", 27'h0000010, 32'h12345678, 1'b1, 5);
        poke_start = 1'b0;
        check("sd_wr_mem", sdram_mem[16], 32'h12345678);
        do_access("unmapped_rd", 27'h0F00000, 32'h0, 1'b0, 1);
        vd = $urandom;
        do_access("vram_wr", 27'h0C00003, vd, 1'b1, 1);
        do_access("vram_rd_b2b", 27'h0C00003, 32'h0, 1'b0, 1);
        do_access("sd_rd", 27'h0000010, 32'h0, 1'b0, 2);
        do_access("rom_wr_noop", 27'h0800005, 32'h11111111, 1'b1, 1);
        do_access("rom_rd_again", 27'h0800005, 32'h0, 1'b0, 1);
        sd_ack_x = 1'b1;
        do_access("io_wr_xack", 27'h0C04022, 32'hCAFEF00D, 1'b1, 3);
        do_access("io_rd_xack", 27'h0C04022, 32'h0, 1'b0, 4);
        sd_ack_x = 1'b0;

        bnd_addrs = '{27'h07FFFFF, 27'h0800000, 27'h08001FF, 27'h0800200, 27'h0BFFFFF,
                      27'h0C03FFF, 27'h0C04000, 27'h0C040FF, 27'h0C04100};
        foreach (bnd_addrs[i]) begin
            vd = $urandom;
            do_access($sformatf("bnd%0d_wr", i), bnd_addrs[i], vd, 1'b1, 1);
            do_access($sformatf("bnd%0d_rd", i), bnd_addrs[i], 32'h0, 1'b0, 2);
        end

        for (int i = 0; i < 40; i++) begin
            rsel = $urandom_range(0, 4);
            case (rsel)
                0: ra = 27'($urandom_range(0, 511));
                1: ra = 27'h0800000 + 27'($urandom_range(0, 511));
                2: ra = 27'h0C00000 + 27'($urandom_range(0, 63));
                3: ra = 27'h0C04000 + 27'($urandom_range(0, 255));
                default: ra = 27'h0C04100 + 27'($urandom_range(0, 32'h073FBEFF));
            endcase
            do_access($sformatf("rnd%0d", i), ra, $urandom, 1'($urandom_range(0, 1)),
                      $urandom_range(1, 6));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

`ifdef MEM_TIMEOUT_EN
        do_access("pre_tmo_rom", 27'h0800005, 32'h0, 1'b0, 1);
        do_access("io_timeout", 27'h0C04010, 32'h0, 1'b0, 0);
`endif

        // Reset during the 10th WAIT cycle of an IO read that never gets an ack
        io_delay = 0;
        address = 27'h0C04011; we = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("rst_mid_busy_before", busy, 1);
        check("rst_mid_req_before", io_req, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q = 32'h0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_io_req", io_req, 0);
        io_ack_x = 1'b1;
        @(posedge clk); #1;
        io_ack_x = 1'b0;
        @(posedge clk); #1;
        check("late_ack_busy", busy, 0);
        check("late_ack_q", q, exp_q);
        do_access("post_rst_rom", 27'h0800005, 32'h0, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
